// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite types for the register-access masters and slaves:
// response codes, the master FSM state encoding and the fixed bus widths.
package axi4lite_pkg;

  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } master_state_e;

endpackage

// File: rtl/axi4lite_master_if.sv
// Bundle of the command/response port and the AXI4-Lite master port of
// axi4lite_master. The master modport is the DUT view; the slave modport is
// the view of whatever sits around it (sequencer plus AXI4-Lite peripheral).
//
// Handshake rule on every channel (cmd, rsp, AW, W, B, AR, R): a transfer
// happens on the rising clk edge where valid and ready are both 1. Once valid
// is raised its payload is held stable and valid stays high until that edge;
// ready may depend on valid, but valid never waits for ready.
interface axi4lite_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // command / response side
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;

  // AXI4-Lite side
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic              m_axi_awvalid;
  logic              m_axi_awready;
  logic [DATA_W-1:0] m_axi_wdata;
  logic [STRB_W-1:0] m_axi_wstrb;
  logic              m_axi_wvalid;
  logic              m_axi_wready;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid;
  logic              m_axi_bready;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [DATA_W-1:0] m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rvalid;
  logic              m_axi_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_write, rsp_rdata, rsp_resp,
    input  rsp_ready,
    output m_axi_awaddr, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_write, rsp_rdata, rsp_resp,
    output rsp_ready,
    input  m_axi_awaddr, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_rready
  );

endinterface

// File: rtl/axi4lite_master.sv
// axi4lite_master: turns single-beat commands into AXI4-Lite transactions,
// one outstanding at a time. Every output is a register so nothing on the
// command side depends combinationally on AXI inputs.
//
// Optional build macro AXI4LITE_MASTER_TIMEOUT_EN adds a watchdog: after
// TIMEOUT_CYCLES cycles stuck in one bus phase the master abandons the
// transaction and reports DECERR. Without it the master waits forever.
module axi4lite_master
  import axi4lite_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  axi4lite_master_if.master bus,
  output master_state_e     state_o
);

  localparam int STRB_W = DATA_W / 8;

  // Elaboration guards: the data path is fixed at 32 bits.
  if (DATA_W != AXI_DATA_W || STRB_W != AXI_STRB_W) begin : g_bad_data_w
    $error("axi4lite_master: DATA_W must be 32");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("axi4lite_master: TIMEOUT_CYCLES must be at least 1");
  end

  master_state_e     state_q;
  logic              cmd_ready_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              bready_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              rsp_valid_q;
  logic              rsp_write_q;
  logic [1:0]        rsp_resp_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  // A write channel is finished once its valid has dropped or is being
  // accepted this cycle; AW and W complete independently in any order.
  logic aw_done;
  logic w_done;
  assign aw_done = !awvalid_q || bus.m_axi_awready;
  assign w_done  = !wvalid_q  || bus.m_axi_wready;

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             busy;
  logic             phase_done;
  logic             tmo_hit;

  // Classify the current state: waiting on the bus, and leaving this cycle.
  always_comb begin
    busy       = 1'b0;
    phase_done = 1'b0;
    case (state_q)
      WR_REQ:  begin busy = 1'b1; phase_done = aw_done && w_done;   end
      WR_RESP: begin busy = 1'b1; phase_done = bus.m_axi_bvalid;    end
      RD_REQ:  begin busy = 1'b1; phase_done = bus.m_axi_arready;   end
      RD_DATA: begin busy = 1'b1; phase_done = bus.m_axi_rvalid;    end
      default: ;
    endcase
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive cycle in one bus phase.
  assign tmo_hit = busy && !phase_done &&
                   (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Cycles spent in the current bus phase; zero on every phase entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (!busy || phase_done) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`endif

  // Transaction FSM with all handshake and response outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_resp_q  <= '0;
      rsp_rdata_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_ready_q && bus.cmd_valid) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= bus.cmd_addr;
            wdata_q     <= bus.cmd_wdata;
            wstrb_q     <= bus.cmd_wstrb;
            rsp_write_q <= bus.cmd_write;
            if (bus.cmd_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (aw_done && w_done) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b1;
            state_q   <= WR_RESP;
          end else begin
            if (awvalid_q && bus.m_axi_awready) awvalid_q <= 1'b0;
            if (wvalid_q && bus.m_axi_wready)   wvalid_q  <= 1'b0;
          end
        end
        WR_RESP: begin
          if (bus.m_axi_bvalid) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= bus.m_axi_bresp;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end
        end
        RD_REQ: begin
          if (bus.m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (bus.m_axi_rvalid) begin
            rready_q    <= 1'b0;
            rsp_rdata_q <= bus.m_axi_rdata;
            rsp_resp_q  <= bus.m_axi_rresp;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end
        end
        RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
      // Abandon the stuck transaction; overrides any partial progress above.
      if (tmo_hit) begin
        awvalid_q   <= 1'b0;
        wvalid_q    <= 1'b0;
        bready_q    <= 1'b0;
        arvalid_q   <= 1'b0;
        rready_q    <= 1'b0;
        rsp_valid_q <= 1'b1;
        rsp_resp_q  <= DECERR;
        rsp_rdata_q <= '0;
        state_q     <= RSP;
      end
`endif
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_write     = rsp_write_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.rsp_resp      = rsp_resp_q;
  assign bus.m_axi_awaddr  = addr_q;
  assign bus.m_axi_awvalid = awvalid_q;
  assign bus.m_axi_wdata   = wdata_q;
  assign bus.m_axi_wstrb   = wstrb_q;
  assign bus.m_axi_wvalid  = wvalid_q;
  assign bus.m_axi_bready  = bready_q;
  assign bus.m_axi_araddr  = addr_q;
  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_rready  = rready_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_axi4lite_master.sv
// Directed testbench for axi4lite_master. A small AXI4-Lite responder with
// configurable AW/W stalls and a blockable AR channel stands in for the
// register slave: 16 words at 0x00-0x3C, SLVERR (read data 0xDEADBEEF) for
// misaligned or out-of-range addresses.
module tb_axi4lite_master;
  import axi4lite_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi4lite_master_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();
  master_state_e dbg_state;

  axi4lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_if),
    .state_o (dbg_state)
  );

  int pass_cnt = 0;
  int check_cnt = 0;
  int last_accept = 0;

  // ---------------- AXI4-Lite responder ----------------
  int          aw_delay = 0;
  int          w_delay = 0;
  bit          ar_en = 1'b1;
  int          aw_wait, w_wait;
  logic        have_aw, have_w;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] mem [16];

  assign bus_if.m_axi_awready = (aw_wait >= aw_delay);
  assign bus_if.m_axi_wready  = (w_wait >= w_delay);
  assign bus_if.m_axi_arready = ar_en;

  wire aw_fire = bus_if.m_axi_awvalid && bus_if.m_axi_awready;
  wire w_fire  = bus_if.m_axi_wvalid && bus_if.m_axi_wready;
  wire ar_fire = bus_if.m_axi_arvalid && bus_if.m_axi_arready;
  wire [31:0] cur_addr = have_aw ? s_addr : bus_if.m_axi_awaddr;
  wire [31:0] cur_data = have_w ? s_wdata : bus_if.m_axi_wdata;
  wire [3:0]  cur_strb = have_w ? s_wstrb : bus_if.m_axi_wstrb;

  function automatic bit is_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'h40);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wait <= 0; w_wait <= 0; have_aw <= 1'b0; have_w <= 1'b0;
      s_addr <= '0; s_wdata <= '0; s_wstrb <= '0;
      bus_if.m_axi_bvalid <= 1'b0; bus_if.m_axi_bresp <= 2'b00;
      bus_if.m_axi_rvalid <= 1'b0; bus_if.m_axi_rresp <= 2'b00;
      bus_if.m_axi_rdata <= '0;
    end else begin
      aw_wait <= (aw_fire || !bus_if.m_axi_awvalid) ? 0 : aw_wait + 1;
      w_wait  <= (w_fire || !bus_if.m_axi_wvalid) ? 0 : w_wait + 1;
      if (aw_fire) begin have_aw <= 1'b1; s_addr <= bus_if.m_axi_awaddr; end
      if (w_fire) begin
        have_w <= 1'b1; s_wdata <= bus_if.m_axi_wdata; s_wstrb <= bus_if.m_axi_wstrb;
      end
      if ((have_aw || aw_fire) && (have_w || w_fire) && !bus_if.m_axi_bvalid) begin
        bus_if.m_axi_bvalid <= 1'b1;
        have_aw <= 1'b0;
        have_w  <= 1'b0;
        bus_if.m_axi_bresp <= is_err(cur_addr) ? 2'b10 : 2'b00;
        if (!is_err(cur_addr))
          for (int b = 0; b < 4; b++)
            if (cur_strb[b]) mem[cur_addr[5:2]][b*8 +: 8] <= cur_data[b*8 +: 8];
      end
      if (bus_if.m_axi_bvalid && bus_if.m_axi_bready) bus_if.m_axi_bvalid <= 1'b0;
      if (ar_fire) begin
        bus_if.m_axi_rvalid <= 1'b1;
        bus_if.m_axi_rresp  <= is_err(bus_if.m_axi_araddr) ? 2'b10 : 2'b00;
        bus_if.m_axi_rdata  <= is_err(bus_if.m_axi_araddr) ? 32'hDEADBEEF
                                                           : mem[bus_if.m_axi_araddr[5:2]];
      end else if (bus_if.m_axi_rvalid && bus_if.m_axi_rready) begin
        bus_if.m_axi_rvalid <= 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output bit ok);
    @(negedge clk);
    bus_if.cmd_valid = 1'b1; bus_if.cmd_write = wr; bus_if.cmd_addr = addr;
    bus_if.cmd_wdata = data; bus_if.cmd_wstrb = strb;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (bus_if.cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin @(posedge clk); #1; last_accept = cyc; end
    bus_if.cmd_valid = 1'b0;
  endtask

  // Latency counts falling-edge samples after the accepting edge.
  task automatic wait_rsp(output int lat, output logic [31:0] rdata,
                          output logic [1:0] resp, output logic wr);
    lat = -1; rdata = '0; resp = '0; wr = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (bus_if.rsp_valid) begin
        lat = i; rdata = bus_if.rsp_rdata; resp = bus_if.rsp_resp; wr = bus_if.rsp_write;
        break;
      end
    end
    if (lat > 0) begin @(posedge clk); #1; end
  endtask

  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output int lat, output logic [31:0] rdata,
                        output logic [1:0] resp, output logic rwr);
    bit ok;
    send_cmd(wr, addr, data, strb, ok);
    if (ok) wait_rsp(lat, rdata, resp, rwr);
    else begin lat = -2; rdata = '0; resp = '0; rwr = 1'b0; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_cnt++; if (bus_if.cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready got %b want 0", bus_if.cmd_ready); else pass_cnt++;
    check_cnt++; if ({bus_if.m_axi_awvalid, bus_if.m_axi_wvalid, bus_if.m_axi_arvalid} !== 3'b000) $display("FAIL rst_axi_valids got %b want 000", {bus_if.m_axi_awvalid, bus_if.m_axi_wvalid, bus_if.m_axi_arvalid}); else pass_cnt++;
    check_cnt++; if ({bus_if.m_axi_bready, bus_if.m_axi_rready} !== 2'b00) $display("FAIL rst_axi_readies got %b want 00", {bus_if.m_axi_bready, bus_if.m_axi_rready}); else pass_cnt++;
    check_cnt++; if (bus_if.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b want 0", bus_if.rsp_valid); else pass_cnt++;
    check_cnt++; if ({bus_if.rsp_resp, bus_if.rsp_rdata, bus_if.m_axi_awaddr} !== 66'h0) $display("FAIL rst_data got %h/%h/%h want 0", bus_if.rsp_resp, bus_if.rsp_rdata, bus_if.m_axi_awaddr); else pass_cnt++;
    check_cnt++; if (dbg_state !== IDLE) $display("FAIL rst_state got %0d want %0d", dbg_state, IDLE); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    check_cnt++; if (bus_if.cmd_ready !== 1'b1) $display("FAIL post_rst_cmd_ready got %b want 1", bus_if.cmd_ready); else pass_cnt++;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic [1:0] rs; logic wr;
    do_txn(1'b1, 32'h04, 32'hCAFEBABE, 4'hF, lat, rd, rs, wr);
    check_cnt++; if (lat !== 3) $display("FAIL wr_latency got %0d want 3", lat); else pass_cnt++;
    check_cnt++; if ({rs, wr, rd} !== {2'b00, 1'b1, 32'h0}) $display("FAIL wr_rsp got resp=%b write=%b rdata=%h want 00/1/0", rs, wr, rd); else pass_cnt++;
    do_txn(1'b0, 32'h04, 32'h0, 4'h0, lat, rd, rs, wr);
    check_cnt++; if (lat !== 3) $display("FAIL rd_latency got %0d want 3", lat); else pass_cnt++;
    check_cnt++; if ({rs, wr, rd} !== {2'b00, 1'b0, 32'hCAFEBABE}) $display("FAIL rd_rsp got resp=%b write=%b rdata=%h want 00/0/cafebabe", rs, wr, rd); else pass_cnt++;
    do_txn(1'b1, 32'h08, 32'h11223344, 4'hF, lat, rd, rs, wr);
    do_txn(1'b1, 32'h08, 32'hAABBCCDD, 4'h5, lat, rd, rs, wr);
    do_txn(1'b0, 32'h08, 32'h0, 4'h0, lat, rd, rs, wr);
    check_cnt++; if (rd !== 32'h11BB33DD) $display("FAIL wstrb_merge got %h want 11bb33dd", rd); else pass_cnt++;
  endtask

  task automatic test_write_stall(input int awd, input int wd, input logic [31:0] addr,
                                  input logic [31:0] data, input int exp_aw,
                                  input int exp_w, input int exp_lat);
    bit ok; int aw_n, w_n, bad_payload, early_b, lat; logic [1:0] rs;
    int rl; logic [31:0] rd; logic [1:0] rrs; logic rwr;
    aw_delay = awd; w_delay = wd;
    aw_n = 0; w_n = 0; bad_payload = 0; early_b = 0; lat = -1; rs = 2'bxx;
    send_cmd(1'b1, addr, data, 4'hF, ok);
    for (int i = 1; i <= 40 && ok; i++) begin
      @(negedge clk);
      if (bus_if.m_axi_awvalid) begin aw_n++; if (bus_if.m_axi_awaddr !== addr) bad_payload++; end
      if (bus_if.m_axi_wvalid) begin w_n++; if (bus_if.m_axi_wdata !== data) bad_payload++; end
      if (bus_if.m_axi_bready && (bus_if.m_axi_awvalid || bus_if.m_axi_wvalid)) early_b++;
      if (bus_if.rsp_valid) begin lat = i; rs = bus_if.rsp_resp; break; end
    end
    if (lat > 0) begin @(posedge clk); #1; end
    check_cnt++; if (aw_n !== exp_aw) $display("FAIL stall_awvalid_cycles got %0d want %0d", aw_n, exp_aw); else pass_cnt++;
    check_cnt++; if (w_n !== exp_w) $display("FAIL stall_wvalid_cycles got %0d want %0d", w_n, exp_w); else pass_cnt++;
    check_cnt++; if (bad_payload !== 0) $display("FAIL stall_payload_stable got %0d bad want 0", bad_payload); else pass_cnt++;
    check_cnt++; if (early_b !== 0) $display("FAIL stall_bready_early got %0d want 0", early_b); else pass_cnt++;
    check_cnt++; if (lat !== exp_lat || rs !== 2'b00) $display("FAIL stall_rsp got lat=%0d resp=%b want %0d/00", lat, rs, exp_lat); else pass_cnt++;
    aw_delay = 0; w_delay = 0;
    do_txn(1'b0, addr, 32'h0, 4'h0, rl, rd, rrs, rwr);
    check_cnt++; if (rd !== data) $display("FAIL stall_readback got %h want %h", rd, data); else pass_cnt++;
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic [1:0] rs; logic wr;
    do_txn(1'b0, 32'h40, 32'h0, 4'h0, lat, rd, rs, wr);
    check_cnt++; if ({rs, rd} !== {2'b10, 32'hDEADBEEF}) $display("FAIL err_read got resp=%b rdata=%h want 10/deadbeef", rs, rd); else pass_cnt++;
    do_txn(1'b1, 32'h02, 32'h12345678, 4'hF, lat, rd, rs, wr);
    check_cnt++; if ({rs, wr, rd} !== {2'b10, 1'b1, 32'h0}) $display("FAIL err_write got resp=%b write=%b rdata=%h want 10/1/0", rs, wr, rd); else pass_cnt++;
  endtask

  task automatic test_rsp_hold();
    bit ok; int bad, lat; logic [31:0] rd0, rd; logic [1:0] rs; logic wr;
    bus_if.rsp_ready = 1'b0;
    send_cmd(1'b0, 32'h04, 32'h0, 4'h0, ok);
    for (int i = 0; i < 20 && !bus_if.rsp_valid; i++) @(negedge clk);
    rd0 = bus_if.rsp_rdata;
    check_cnt++; if (rd0 !== 32'hCAFEBABE) $display("FAIL hold_rdata got %h want cafebabe", rd0); else pass_cnt++;
    bus_if.cmd_valid = 1'b1; bus_if.cmd_write = 1'b1; bus_if.cmd_addr = 32'h18;
    bus_if.cmd_wdata = 32'hA5A5A5A5; bus_if.cmd_wstrb = 4'hF;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus_if.rsp_valid || bus_if.rsp_rdata !== rd0 || bus_if.rsp_resp !== 2'b00 ||
          bus_if.rsp_write !== 1'b0 || bus_if.cmd_ready !== 1'b0 || dbg_state !== RSP) bad++;
    end
    check_cnt++; if (bad !== 0) $display("FAIL hold_stable got %0d bad cycles want 0", bad); else pass_cnt++;
    bus_if.rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_cnt++; if ({bus_if.rsp_valid, bus_if.cmd_ready} !== 2'b01) $display("FAIL hold_release got valid/ready=%b want 01", {bus_if.rsp_valid, bus_if.cmd_ready}); else pass_cnt++;
    @(posedge clk); #1;
    bus_if.cmd_valid = 1'b0;
    check_cnt++; if (dbg_state !== WR_REQ) $display("FAIL hold_next_accept got state %0d want %0d", dbg_state, WR_REQ); else pass_cnt++;
    wait_rsp(lat, rd, rs, wr);
    check_cnt++; if ({lat, rs, wr} !== {32'd3, 2'b00, 1'b1}) $display("FAIL hold_next_rsp got lat=%0d resp=%b write=%b want 3/00/1", lat, rs, wr); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, a1; logic [31:0] rd1, rd2; logic [1:0] rs; logic wr;
    do_txn(1'b0, 32'h18, 32'h0, 4'h0, lat1, rd1, rs, wr);
    a1 = last_accept;
    do_txn(1'b0, 32'h04, 32'h0, 4'h0, lat2, rd2, rs, wr);
    check_cnt++; if (last_accept - a1 !== 4) $display("FAIL b2b_spacing got %0d want 4", last_accept - a1); else pass_cnt++;
    check_cnt++; if ({rd1, rd2} !== {32'hA5A5A5A5, 32'hCAFEBABE}) $display("FAIL b2b_data got %h %h want a5a5a5a5 cafebabe", rd1, rd2); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ok; int spurious, lat; logic [31:0] rd; logic [1:0] rs; logic wr;
    aw_delay = 20;
    send_cmd(1'b1, 32'h14, 32'h00000077, 4'hF, ok);
    repeat (3) @(negedge clk);
    check_cnt++; if (bus_if.m_axi_awvalid !== 1'b1) $display("FAIL midrst_pre_awvalid got %b want 1", bus_if.m_axi_awvalid); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    check_cnt++; if ({bus_if.m_axi_awvalid, bus_if.m_axi_wvalid, bus_if.rsp_valid} !== 3'b000) $display("FAIL midrst_valids got %b want 000", {bus_if.m_axi_awvalid, bus_if.m_axi_wvalid, bus_if.rsp_valid}); else pass_cnt++;
    check_cnt++; if (dbg_state !== IDLE) $display("FAIL midrst_state got %0d want %0d", dbg_state, IDLE); else pass_cnt++;
    aw_delay = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (5) begin @(negedge clk); if (bus_if.rsp_valid) spurious++; end
    check_cnt++; if (spurious !== 0) $display("FAIL midrst_no_rsp got %0d want 0", spurious); else pass_cnt++;
    do_txn(1'b1, 32'h14, 32'h600DF00D, 4'hF, lat, rd, rs, wr);
    do_txn(1'b0, 32'h14, 32'h0, 4'h0, lat, rd, rs, wr);
    check_cnt++; if ({lat, rs, rd} !== {32'd3, 2'b00, 32'h600DF00D}) $display("FAIL midrst_recover got lat=%0d resp=%b rdata=%h want 3/00/600df00d", lat, rs, rd); else pass_cnt++;
  endtask

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    bit ok; int ar_n, lat; logic [31:0] rd; logic [1:0] rs; logic wr;
    ar_en = 1'b0;
    send_cmd(1'b0, 32'h04, 32'h0, 4'h0, ok);
    ar_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus_if.m_axi_arvalid) break;
      ar_n++;
    end
    check_cnt++; if (ar_n !== 16) $display("FAIL tmo_arvalid_cycles got %0d want 16", ar_n); else pass_cnt++;
    check_cnt++; if ({bus_if.rsp_valid, bus_if.rsp_resp, bus_if.rsp_rdata} !== {1'b1, 2'b11, 32'h0}) $display("FAIL tmo_rsp got valid=%b resp=%b rdata=%h want 1/11/0", bus_if.rsp_valid, bus_if.rsp_resp, bus_if.rsp_rdata); else pass_cnt++;
    @(posedge clk); #1;
    ar_en = 1'b1;
    do_txn(1'b0, 32'h04, 32'h0, 4'h0, lat, rd, rs, wr);
    check_cnt++; if ({rs, rd} !== {2'b00, 32'hCAFEBABE}) $display("FAIL tmo_recover got resp=%b rdata=%h want 00/cafebabe", rs, rd); else pass_cnt++;
  endtask
`else
  task automatic test_no_timeout();
    bit ok; int ar_n, rsp_n, lat; logic [31:0] rd; logic [1:0] rs; logic wr;
    ar_en = 1'b0;
    send_cmd(1'b0, 32'h04, 32'h0, 4'h0, ok);
    ar_n = 0; rsp_n = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus_if.m_axi_arvalid) ar_n++;
      if (bus_if.rsp_valid) rsp_n++;
    end
    check_cnt++; if ({ar_n, rsp_n} !== {32'd40, 32'd0}) $display("FAIL notmo_wait got arvalid=%0d rsp=%0d want 40/0", ar_n, rsp_n); else pass_cnt++;
    rst_n = 1'b0;
    @(negedge clk);
    ar_en = 1'b1;
    rst_n = 1'b1;
    do_txn(1'b0, 32'h04, 32'h0, 4'h0, lat, rd, rs, wr);
    check_cnt++; if ({rs, rd} !== {2'b00, 32'hCAFEBABE}) $display("FAIL notmo_recover got resp=%b rdata=%h want 00/cafebabe", rs, rd); else pass_cnt++;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    bus_if.cmd_valid = 1'b0; bus_if.cmd_write = 1'b0; bus_if.cmd_addr = '0;
    bus_if.cmd_wdata = '0; bus_if.cmd_wstrb = '0; bus_if.rsp_ready = 1'b1;
    test_reset();
    test_write_read();
    test_write_stall(5, 0, 32'h0C, 32'h12345678, 6, 1, 8);
    test_write_stall(0, 3, 32'h10, 32'h9ABCDEF0, 1, 4, 6);
    test_errors();
    test_rsp_hold();
    test_back_to_back();
    test_reset_mid();
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi4lite_master.md
Name: axi4lite_master

Overview:
- AXI4-Lite initiator that converts a simple single-beat command/response interface into AXI4-Lite transactions.
- Drives one outstanding transaction at a time. Connects directly to the team's AXI4-Lite register slave and to any AXI4-Lite peripheral.
- Used by test/bring-up sequencers and the boot controller for register access.

Parameters:
- ADDR_W, 32, address width of cmd_addr and AW/AR.
- DATA_W, 32, data width; must be 32.
- TIMEOUT_CYCLES, 256, watchdog limit in cycles (only used with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when valid&ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  DATA_W/8  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when valid&ready
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_resp  out  2  AXI resp (00 OKAY, 10 SLVERR, 11 DECERR/timeout)
- m_axi_awaddr/awvalid out, awready in
- m_axi_wdata/wstrb/wvalid out, wready in
- m_axi_bresp in 2, bvalid in, bready out
- m_axi_araddr/arvalid out, arready in
- m_axi_rdata in, rresp in 2, rvalid in, rready out

Behaviour:
- Clock and reset: clk; rst_n asynchronous, active-low.
- Reset values: all valid/ready outputs 0, all data/addr/resp outputs 0, FSM=IDLE.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1 only in IDLE (registered state, not combinational on AXI inputs).
  - On cmd handshake: latch addr/wdata/wstrb/write.
  - Write → WR_REQ with awvalid=1 and wvalid=1 in the next cycle.
  - Read → RD_REQ with arvalid=1 in the next cycle.
- WR_REQ:
  - awvalid and wvalid drop independently, each on the cycle after its own handshake.
  - AW-before-W, W-before-AW and simultaneous handshakes all supported.
  - awaddr/wdata/wstrb held stable while the corresponding valid=1. No valid is deasserted before its handshake.
  - Once both handshakes are done → WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid&bready: latch bresp into rsp_resp; rsp_write=1; rsp_rdata=0; → RSP.
  - A bvalid asserted before WR_RESP is ignored until WR_RESP. The slave holds bvalid per protocol.
- RD_REQ: arvalid=1, araddr stable; on handshake → RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid&rready: latch rdata/rresp; rsp_write=0; → RSP.
- RSP:
  - rsp_valid=1 with stable fields.
  - On rsp_ready: → IDLE; cmd_ready reasserts next cycle.
- Latency from cmd handshake to rsp_valid, zero-wait slave:
  - Write: 3 cycles.
  - Read: 3 cycles.
  - Back-to-back throughput: 1 transaction per 4 cycles minimum.
- No address checking in the master. Error responses pass through unchanged.
- Reset mid-transaction: all valids drop immediately (async); FSM=IDLE; the in-flight command is lost and no response is issued.
- rsp_ready held high: rsp_valid is a 1-cycle pulse.

Optional Feature:
- Macro: AXI4LITE_MASTER_TIMEOUT_EN.
- With the macro:
  - A counter resets on entry to WR_REQ, WR_RESP, RD_REQ or RD_DATA and increments each cycle spent there.
  - On reaching TIMEOUT_CYCLES: all AXI valids/readies are forced to 0 and the FSM goes to RSP with rsp_resp=2'b11 and rsp_rdata=0.
  - This is a fatal error path; the downstream slave must be reset before further use.
- Without the macro: no counter, no timeout; the master waits indefinitely.

Decomposition:
- Package axi4lite_pkg:
  - typedef resp_e: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - typedef master_state_e for the FSM.
  - localparams AXI_DATA_W=32 and AXI_STRB_W=4.
  - Shared with the slave.
- No sub-module; single FSM file, roughly 200 lines.

Test Plan:
- Write 0x04 ← 0xCAFEBABE, wstrb 0xF, zero-wait slave → rsp_resp=00, rsp_write=1, rsp_rdata=0; read 0x04 returns 0xCAFEBABE, rresp=00.
- Slave holds awready=0 for 5 cycles, wready immediate → wvalid drops after 1 cycle; awvalid/awaddr held stable 5 cycles; bready only after both handshakes; response OKAY.
- Read 0x40 (out of range) → rsp_resp=10, rsp_rdata=0xDEADBEEF; write 0x02 (misaligned) → rsp_resp=10.
- rsp_ready held low 10 cycles after a read → rsp_valid and fields stable, cmd_ready=0 throughout; a new cmd is accepted only after RSP is consumed.
- Assert rst_n=0 while awvalid=1 → awvalid=0 immediately, no rsp_valid; next cmd after reset completes normally.
- With AXI4LITE_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never asserts arready → arvalid drops at cycle 16, rsp_resp=11, rsp_rdata=0.
